pad_hdx_ctrl: RTL and testbench

PAD_HDX_CTRL -- requirements
Module: pad_hdx_ctrl

---
 rtl/pad_hdx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pad_hdx_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pad_hdx_ctrl.sv
// pad_hdx_ctrl: half-duplex byte request/response over one bidirectional pad.
// Define PAD_HDX_PARITY_EN to add an even-parity bit after the data byte.
module pad_hdx_ctrl #(
  parameter int BIT_CYC = 4,
  parameter int TA_CYC  = 2,
  parameter int TO_CYC  = 64
) (
  input  logic       ck,
  input  logic       rn,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [1:0] rx_err,
  output logic       busy,
  output logic       pad_i,
  output logic       pad_oen,
  input  logic       pad_c
);

`ifdef PAD_HDX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  localparam int M1   = (BIT_CYC > TA_CYC) ? BIT_CYC : TA_CYC;
  localparam int MAXC = (M1 > TO_CYC) ? M1 : TO_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'(BIT_CYC / 2);
  localparam logic [CW-1:0] TA_LAST  = CW'(TA_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    TX,
    TA,
    RX_WAIT,
    RX,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [NB-1:0]   sh_q, sh_d;
  logic [7:0]      rxsh_q, rxsh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [1:0]      rx_err_q, rx_err_d;
  logic            sy1_q, sy1_d;
  logic            sy2_q, sy2_d;
  logic            rdy_q, rdy_d;
  logic            rx_s;
  logic            frame_bad;
  logic [NB-1:0]   frame;

`ifdef PAD_HDX_PARITY_EN
  logic par_q, par_d;
  assign frame     = {1'b1, ^tx_data, tx_data, 1'b0};
  assign frame_bad = ~rx_s | (par_q != ^rxsh_q);
`else
  assign frame     = {1'b1, tx_data, 1'b0};
  assign frame_bad = ~rx_s;
`endif

  assign rx_s = sy2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rxsh_d    = rxsh_q;
    rx_data_d = rx_data_q;
    rx_err_d  = rx_err_q;
    sy1_d     = pad_c;
    sy2_d     = sy1_q;
    rdy_d     = 1'b1;
`ifdef PAD_HDX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = TX;
          cnt_d   = '0;
          bit_d   = '0;
          sh_d    = frame;
        end
      end
      TX: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {1'b1, sh_q[NB-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = TA;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TA: begin
        if (cnt_q == TA_LAST) begin
          state_d = RX_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT: begin
        // the low cycle itself is offset 0, so RX starts at offset 1
        if (!rx_s) begin
          state_d = RX;
          cnt_d   = CW'(1);
          bit_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          rx_err_d = 2'b01;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q == BIT_MID && bit_q != 4'd0) begin
          if (bit_q <= 4'd8) begin
            rxsh_d = {rx_s, rxsh_q[7:1]};
          end
`ifdef PAD_HDX_PARITY_EN
          if (bit_q == 4'd9) begin
            par_d = rx_s;
          end
`endif
          if (bit_q == LAST_BIT) begin
            state_d   = DONE;
            cnt_d     = '0;
            bit_d     = '0;
            rx_data_d = rxsh_q;
            rx_err_d  = {frame_bad, 1'b0};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '1;
      rxsh_q    <= '0;
      rx_data_q <= '0;
      rx_err_q  <= '0;
      sy1_q     <= 1'b1;
      sy2_q     <= 1'b1;
      rdy_q     <= 1'b0;
`ifdef PAD_HDX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rxsh_q    <= rxsh_d;
      rx_data_q <= rx_data_d;
      rx_err_q  <= rx_err_d;
      sy1_q     <= sy1_d;
      sy2_q     <= sy2_d;
      rdy_q     <= rdy_d;
`ifdef PAD_HDX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx_ready = (state_q == IDLE) && rdy_q;
  assign busy     = (state_q != IDLE);
  assign rx_valid = (state_q == DONE);
  assign pad_oen  = (state_q != TX);
  assign pad_i    = (state_q == TX) ? sh_q[0] : 1'b1;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_pad_hdx_ctrl.sv
// tb_pad_hdx_ctrl: randomized transactions against a frame-level model of
// the pad bus, responder and expected receive results.
module tb_pad_hdx_ctrl;
  localparam int B   = 4;
  localparam int TAC = 2;
  localparam int TOC = 64;

  logic       ck = 1'b0;
  logic       rn;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       busy;
  logic       pad_i;
  logic       pad_oen;
  logic       pad_c;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp_data;
  logic [1:0] exp_err;

  pad_hdx_ctrl #(
    .BIT_CYC(B),
    .TA_CYC (TAC),
    .TO_CYC (TOC)
  ) dut (
    .ck      (ck),
    .rn      (rn),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_err  (rx_err),
    .busy    (busy),
    .pad_i   (pad_i),
    .pad_oen (pad_oen),
    .pad_c   (pad_c)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 no responder, 1 good reply, 2 reply with stop bit 0.
  // d: responder start, in cycles after the pad is released.
  task automatic run_txn(input logic [7:0] b, input int mode, input int d,
                         input logic [7:0] rb, input bit pulse);
    logic [9:0] tf;
    logic [9:0] rf;
    logic       resp;
    int         s;
    int         lat;
    int         m;
    int         j;
    bit         seen;
    tf  = {1'b1, b, 1'b0};
    rf  = {(mode == 2) ? 1'b0 : 1'b1, rb, 1'b0};
    s   = 10 * B + TAC + d;
    lat = (mode == 0) ? 10 * B + TAC + TOC : s + 2 + 9 * B + B / 2 + 1;
    if (mode != 0) exp_data = rb;
    exp_err = (mode == 0) ? 2'b01 : (mode == 2) ? 2'b10 : 2'b00;
    chk("ready_idle", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge ck);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    j    = 0;
    seen = 1'b0;
    while (!seen && j < lat + 20) begin
      if (j < 10 * B) begin
        chk("oen_tx", pad_oen, 0);
        chk("pad_i_tx", pad_i, tf[j / B]);
      end else if (j < 10 * B + TAC) begin
        chk("oen_ta", pad_oen, 1);
        chk("pad_i_ta", pad_i, 1);
      end
      chk("busy_txn", busy, 1);
      if (rx_valid) begin
        seen = 1'b1;
        chk("rx_lat", j, lat);
        chk("rx_data", rx_data, exp_data);
        chk("rx_err", rx_err, exp_err);
      end
      m    = j - s;
      resp = (mode != 0 && m >= 0 && m < 10 * B) ? rf[m / B] : 1'b1;
      pad_c = pad_oen ? resp : pad_i;
      tx_valid = pulse && !seen && ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      j++;
      @(negedge ck);
    end
    tx_valid = 1'b0;
    pad_c    = 1'b1;
    chk("done_seen", seen, 1);
    chk("valid_pulse", rx_valid, 0);
    chk("hold_data", rx_data, exp_data);
    chk("hold_err", rx_err, exp_err);
    for (int k = 0; k < 4; k++) begin
      chk("idle_oen", pad_oen, 1);
      chk("idle_busy", busy, 0);
      chk("idle_ready", tx_ready, 1);
      @(negedge ck);
    end
  endtask

  task automatic mid_reset(input logic [7:0] b);
    logic [9:0] tf;
    tf = {1'b1, b, 1'b0};
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge ck);
    tx_valid = 1'b0;
    for (int j = 0; j < 5 * B + 1; j++) begin
      pad_c = pad_oen ? 1'b1 : pad_i;
      @(negedge ck);
    end
    chk("b5_oen", pad_oen, 0);
    chk("b5_pad_i", pad_i, tf[5]);
    rn = 1'b0;
    tx_valid = 1'b1;
    @(negedge ck);
    chk("mrst_oen", pad_oen, 1);
    chk("mrst_pad_i", pad_i, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ready", tx_ready, 0);
    chk("mrst_data", rx_data, 0);
    chk("mrst_err", rx_err, 0);
    exp_data = 8'h00;
    exp_err  = 2'b00;
    pad_c    = 1'b1;
    tx_valid = 1'b0;
    @(negedge ck);
    rn = 1'b1;
    @(negedge ck);
    chk("mrel_ready", tx_ready, 1);
    chk("mrel_oen", pad_oen, 1);
  endtask

  initial begin
    rn       = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    pad_c    = 1'b1;
    exp_data = 8'h00;
    exp_err  = 2'b00;
    repeat (2) @(negedge ck);
    chk("rst_oen", pad_oen, 1);
    chk("rst_pad_i", pad_i, 1);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    rn = 1'b1;
    @(negedge ck);
    chk("rel_ready", tx_ready, 1);

    run_txn(8'hA5, 1, 5, 8'h3C, 1'b0);
    run_txn(8'($urandom), 0, 0, 8'h00, 1'b0);
    run_txn(8'($urandom), 2, $urandom_range(0, 50), 8'h5A, 1'b0);
    run_txn(8'($urandom), 1, 0, 8'($urandom), 1'b1);
    run_txn(8'($urandom), 1, 59, 8'($urandom), 1'b0);
    for (int n = 0; n < 8; n++) begin
      run_txn(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 50),
              8'($urandom), 1'($urandom));
    end
    mid_reset(8'($urandom));
    run_txn(8'($urandom), 1, $urandom_range(0, 50), 8'($urandom), 1'b1);
    run_txn(8'($urandom), 0, 0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
